// File: rtl/vx_ti_mem_responder.sv
// vx_ti_mem_responder
//   Memory-side responder for the TI unit cache request lanes. NUM_REQS
//   request lanes are round-robin arbitrated onto one single-port RAM, one
//   request per cycle. Read data (and optional write acks) return through a
//   per-lane response FIFO together with the request tag.
//
// Ports (lane ports are NUM_REQS-wide arrays)
//   clk, reset                     clock, synchronous active-high reset
//   req_valid/rw/addr/data/byteen/tag   request channel (rw: 1 = write)
//   req_ready                      request accepted this cycle
//   rsp_valid/data/tag             response queue head
//   rsp_ready                      consumer pops the head
//
// Configuration
//   VX_TI_MEM_WRITE_ACK_EN  when defined, accepted writes return a response
//                           (tag echoed, data = 0) and consume a credit.
//   RCACHE_NUM_REQS         default lane count (4 if not defined).

`ifndef RCACHE_NUM_REQS
`define RCACHE_NUM_REQS 4
`endif

module vx_ti_mem_responder #(
  parameter int NUM_REQS        = `RCACHE_NUM_REQS,
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int TAG_WIDTH       = 8,
  parameter int DEPTH           = 1024,
  parameter int RSP_QUEUE_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQS-1:0]     req_valid,
  input  logic [NUM_REQS-1:0]     req_rw,
  input  logic [ADDR_WIDTH-1:0]   req_addr   [NUM_REQS],
  input  logic [DATA_WIDTH-1:0]   req_data   [NUM_REQS],
  input  logic [DATA_WIDTH/8-1:0] req_byteen [NUM_REQS],
  input  logic [TAG_WIDTH-1:0]    req_tag    [NUM_REQS],
  output logic [NUM_REQS-1:0]     req_ready,
  output logic [NUM_REQS-1:0]     rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data   [NUM_REQS],
  output logic [TAG_WIDTH-1:0]    rsp_tag    [NUM_REQS],
  input  logic [NUM_REQS-1:0]     rsp_ready
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int RAM_AW = $clog2(DEPTH);
  localparam int LW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int PW     = $clog2(RSP_QUEUE_DEPTH);
  localparam int CW     = $clog2(RSP_QUEUE_DEPTH + 1);

`ifdef VX_TI_MEM_WRITE_ACK_EN
  localparam bit WRITE_ACK = 1'b1;
`else
  localparam bit WRITE_ACK = 1'b0;
`endif

  // Storage
  logic [DATA_WIDTH-1:0] ram    [DEPTH];
  logic [DATA_WIDTH-1:0] q_data [NUM_REQS][RSP_QUEUE_DEPTH];
  logic [TAG_WIDTH-1:0]  q_tag  [NUM_REQS][RSP_QUEUE_DEPTH];

  // Control state
  logic [LW-1:0] rr_q, rr_d;
  logic          hold_q, hold_d;
  logic [CW-1:0] pend_q   [NUM_REQS];
  logic [CW-1:0] pend_d   [NUM_REQS];
  logic [PW-1:0] wr_ptr_q [NUM_REQS];
  logic [PW-1:0] wr_ptr_d [NUM_REQS];
  logic [PW-1:0] rd_ptr_q [NUM_REQS];
  logic [PW-1:0] rd_ptr_d [NUM_REQS];

  // Grant path
  logic                  active;
  logic [NUM_REQS-1:0]   eligible;
  logic                  gnt_valid;
  logic [LW-1:0]         gnt_idx;
  logic                  gnt_rw;
  logic [RAM_AW-1:0]     gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_wdata;
  logic [BE_W-1:0]       gnt_byteen;
  logic                  push;
  logic [NUM_REQS-1:0]   push_lane;
  logic [NUM_REQS-1:0]   pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  unused_addr_hi;

  // Both ready and response valid stay low during reset and for one cycle
  // after it is released.
  assign active = ~reset & ~hold_q;

  // A lane needs a credit only if its request will produce a response.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    eligible = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = active & req_valid[i]
                  & ((pend_q[i] < CW'(RSP_QUEUE_DEPTH)) | (req_rw[i] & ~WRITE_ACK));
    end
  end

  // Round-robin search starting at rr_q; first eligible lane wins.
  always_comb begin
    int cand;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand = (int'(rr_q) + k) % NUM_REQS;
      if (!gnt_valid && eligible[LW'(cand)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = LW'(cand);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      req_ready[i] = gnt_valid && (gnt_idx == LW'(i));
      rsp_valid[i] = active && (pend_q[i] != '0);
      rsp_data[i]  = q_data[i][rd_ptr_q[i]];
      rsp_tag[i]   = q_tag[i][rd_ptr_q[i]];
    end
  end

  assign gnt_rw     = req_rw[gnt_idx];
  assign gnt_addr   = req_addr[gnt_idx][RAM_AW-1:0];
  assign gnt_wdata  = req_data[gnt_idx];
  assign gnt_byteen = req_byteen[gnt_idx];
  assign push       = gnt_valid & (~gnt_rw | WRITE_ACK);
  assign push_lane  = push ? req_ready : '0;
  assign pop        = rsp_valid & rsp_ready;
  // Reads capture the pre-write RAM word; write acks carry zero data.
  assign push_data  = gnt_rw ? '0 : ram[gnt_addr];

  // Upper address bits are ignored: the RAM index wraps modulo DEPTH.
  always_comb begin
    unused_addr_hi = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      unused_addr_hi = unused_addr_hi ^ (^req_addr[i][ADDR_WIDTH-1:RAM_AW]);
    end
  end

  always_comb begin
    rr_d   = rr_q;
    hold_d = reset;
    for (int i = 0; i < NUM_REQS; i++) begin
      pend_d[i]   = pend_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      if (push_lane[i]) wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
      if (pop[i])       rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      if (push_lane[i] && !pop[i])      pend_d[i] = pend_q[i] + CW'(1);
      else if (!push_lane[i] && pop[i]) pend_d[i] = pend_q[i] - CW'(1);
    end
    if (gnt_valid) rr_d = (gnt_idx == LW'(NUM_REQS - 1)) ? '0 : gnt_idx + LW'(1);
    if (reset) begin
      rr_d = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
        pend_d[i]   = '0;
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    rr_q     <= rr_d;
    hold_q   <= hold_d;
    pend_q   <= pend_d;
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
  end

  // NOTE: RAM and queue storage have no reset; emptiness is tracked by pend and the pointers.
  always_ff @(posedge clk) begin
    if (gnt_valid && gnt_rw) begin
      for (int b = 0; b < BE_W; b++) begin
        if (gnt_byteen[b]) ram[gnt_addr][b*8 +: 8] <= gnt_wdata[b*8 +: 8];
      end
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      if (push_lane[i]) begin
        q_data[i][wr_ptr_q[i]] <= push_data;
        q_tag[i][wr_ptr_q[i]]  <= req_tag[gnt_idx];
      end
    end
  end

endmodule

// File: tb/tb_vx_ti_mem_responder.sv
// Self-checking bench for vx_ti_mem_responder (4 lanes, 64-bit words,
// 1024-word RAM, 2-entry response queues). A behavioural model (word array,
// per-lane response queues, round-robin pointer) predicts every cycle's
// req_ready and response head; directed steps cover the documented cases.
module tb_vx_ti_mem_responder;

  localparam int N     = 4;
  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int TW    = 8;
  localparam int DEPTH = 1024;
  localparam int QD    = 2;

`ifdef VX_TI_MEM_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    bit            known;
    logic [TW-1:0] tag;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid, req_rw, req_ready, rsp_valid, rsp_ready;
  logic [AW-1:0] req_addr   [N];
  logic [DW-1:0] req_data   [N];
  logic [7:0]    req_byteen [N];
  logic [TW-1:0] req_tag    [N];
  logic [DW-1:0] rsp_data   [N];
  logic [TW-1:0] rsp_tag    [N];

  vx_ti_mem_responder #(
    .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
    .DEPTH(DEPTH), .RSP_QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_data(req_data), .req_byteen(req_byteen), .req_tag(req_tag),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  ent_t          mq [N][$];
  logic [DW-1:0] mmem   [DEPTH];
  bit            mknown [DEPTH];
  int            m_rr = 0;
  bit            m_hold = 1'b0;
  int            last_grant = -1;
  int            acc_cnt [N];
  logic [TW-1:0] tag1;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return AW'($urandom_range(0, 31)) | (AW'($urandom_range(0, 7)) << 10);
  endfunction

  task automatic model_accept(input int g);
    int   idx;
    ent_t e;
    idx = int'(req_addr[g] & AW'(DEPTH - 1));
    e.tag = req_tag[g];
    if (req_rw[g]) begin
      for (int b = 0; b < 8; b++)
        if (req_byteen[g][b]) mmem[idx][b*8 +: 8] = req_data[g][b*8 +: 8];
      if (req_byteen[g] == 8'hFF) mknown[idx] = 1'b1;
      if (ACK) begin
        e.data  = '0;
        e.known = 1'b1;
        mq[g].push_back(e);
      end
    end else begin
      e.data  = mmem[idx];
      e.known = mknown[idx];
      mq[g].push_back(e);
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int g;
    bit en;
    bit rst_s;
    bit pop [N];
    @(negedge clk);
    en = !reset && !m_hold;
    g  = -1;
    for (int k = 0; k < N; k++) begin
      int l;
      l = (m_rr + k) % N;
      if (g < 0 && en && req_valid[l] && (mq[l].size() < QD || (req_rw[l] && !ACK))) g = l;
    end
    for (int i = 0; i < N; i++) begin
      bit ev;
      ev = en && (mq[i].size() > 0);
      check($sformatf("req_ready[%0d]", i), 64'(req_ready[i]), 64'(g == i));
      check($sformatf("rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'(ev));
      if (ev) begin
        check($sformatf("rsp_tag[%0d]", i), 64'(rsp_tag[i]), 64'(mq[i][0].tag));
        if (mq[i][0].known) check($sformatf("rsp_data[%0d]", i), rsp_data[i], mq[i][0].data);
      end
      pop[i] = ev && rsp_ready[i];
      if (req_ready[i] === 1'b1) acc_cnt[i]++;
    end
    rst_s      = reset;
    last_grant = g;
    @(posedge clk);
    if (rst_s) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr   = 0;
      m_hold = 1'b1;
    end else begin
      m_hold = 1'b0;
      for (int i = 0; i < N; i++) if (pop[i]) void'(mq[i].pop_front());
      if (g >= 0) begin
        model_accept(g);
        m_rr = (g + 1) % N;
      end
    end
    #1;
  endtask

  task automatic do_req(input int lane, input bit rw, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [7:0] be, input logic [TW-1:0] tag);
    bit got;
    got = 1'b0;
    req_valid[lane]  = 1'b1;
    req_rw[lane]     = rw;
    req_addr[lane]   = addr;
    req_data[lane]   = data;
    req_byteen[lane] = be;
    req_tag[lane]    = tag;
    for (int n = 0; n < 50 && !got; n++) begin
      cycle();
      if (last_grant == lane) got = 1'b1;
    end
    check($sformatf("grant_wait[%0d]", lane), 64'(got), 64'd1);
    req_valid[lane] = 1'b0;
  endtask

  task automatic new_read(input int lane);
    req_valid[lane]  = 1'b1;
    req_rw[lane]     = 1'b0;
    req_addr[lane]   = rand_addr();
    req_data[lane]   = {$urandom, $urandom};
    req_byteen[lane] = 8'($urandom);
    req_tag[lane]    = TW'($urandom);
  endtask

  initial begin
    logic [DW-1:0] w;
    reset     = 1'b1;
    req_valid = '0;
    req_rw    = '0;
    rsp_ready = '1;
    for (int i = 0; i < N; i++) begin
      req_addr[i] = '0; req_data[i] = '0; req_byteen[i] = '0; req_tag[i] = '0;
      acc_cnt[i]  = 0;
    end
    for (int a = 0; a < DEPTH; a++) begin
      mmem[a] = '0; mknown[a] = 1'b0;
    end

    // Reset and the post-reset quiet cycle
    repeat (3) cycle();
    reset = 1'b0;
    cycle();

    // Preload the 32 words used by the randomized traffic
    for (int a = 0; a < 32; a++) do_req(0, 1'b1, AW'(a), {$urandom, $urandom}, 8'hFF, TW'(a));
    cycle();

    // Full write then read-back with one-cycle latency
    do_req(0, 1'b1, 32'h10, 64'h1122334455667788, 8'hFF, 8'h01);
    cycle();
    rsp_ready[0] = 1'b0;
    do_req(0, 1'b0, 32'h10, '0, 8'h00, 8'h05);
    #2;
    check("rd_valid", 64'(rsp_valid[0]), 64'd1);
    check("rd_data", rsp_data[0], 64'h1122334455667788);
    check("rd_tag", 64'(rsp_tag[0]), 64'h05);
    rsp_ready[0] = 1'b1;
    cycle();

    // Partial byte-enable write
    do_req(0, 1'b1, 32'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 8'h02);
    cycle();
    rsp_ready[0] = 1'b0;
    do_req(0, 1'b0, 32'h10, '0, 8'h00, 8'h06);
    #2;
    check("be_data", rsp_data[0], 64'h11223344AAAAAAAA);
    rsp_ready[0] = 1'b1;
    cycle();

    // Address wrap: 0x400 aliases word 0
    w = {$urandom, $urandom};
    do_req(0, 1'b1, 32'h400, w, 8'hFF, 8'h03);
    cycle();
    rsp_ready[0] = 1'b0;
    do_req(0, 1'b0, 32'h0, '0, 8'h00, 8'h07);
    #2;
    check("wrap_data", rsp_data[0], w);
    rsp_ready[0] = 1'b1;
    cycle();

    // Fairness: four lanes with continuous reads for 100 cycles
    for (int i = 0; i < N; i++) begin acc_cnt[i] = 0; new_read(i); end
    repeat (100) begin
      cycle();
      if (last_grant >= 0) new_read(last_grant);
    end
    req_valid = '0;
    for (int i = 0; i < N; i++) check($sformatf("rr_share[%0d]", i), 64'(acc_cnt[i]), 64'd25);
    repeat (3) cycle();

    // Backpressure on lane 1: two credits, then blocked while others proceed
    rsp_ready = 4'b1101;
    tag1 = 8'h40;
    for (int i = 0; i < N; i++) begin acc_cnt[i] = 0; new_read(i); end
    req_tag[1] = tag1;
    repeat (20) begin
      cycle();
      if (last_grant >= 0) begin
        new_read(last_grant);
        if (last_grant == 1) begin tag1 = tag1 + 8'd1; req_tag[1] = tag1; end
      end
    end
    check("bp_lane1_accepts", 64'(acc_cnt[1]), 64'd2);
    check("bp_lane0_progress", 64'(acc_cnt[0] > 3), 64'd1);
    check("bp_lane3_progress", 64'(acc_cnt[3] > 3), 64'd1);
    rsp_ready = '1;
    acc_cnt[1] = 0;
    repeat (20) begin
      cycle();
      if (last_grant >= 0) begin
        new_read(last_grant);
        if (last_grant == 1) begin tag1 = tag1 + 8'd1; req_tag[1] = tag1; end
      end
    end
    check("bp_lane1_resumed", 64'(acc_cnt[1] > 2), 64'd1);
    req_valid = '0;
    repeat (3) cycle();

    // Randomized mixed traffic with occasional resets
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && last_grant != i)) begin
          req_valid[i]  = ($urandom_range(0, 3) != 0);
          req_rw[i]     = 1'($urandom_range(0, 1));
          req_addr[i]   = rand_addr();
          req_data[i]   = {$urandom, $urandom};
          req_byteen[i] = 8'($urandom);
          req_tag[i]    = TW'($urandom);
        end
      end
      rsp_ready = 4'($urandom);
      reset     = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (4) cycle();

    // Reset with two queued responses on lane 2
    rsp_ready[2] = 1'b0;
    do_req(2, 1'b0, rand_addr(), '0, 8'h00, 8'h21);
    do_req(2, 1'b0, rand_addr(), '0, 8'h00, 8'h22);
    #2;
    check("q2_valid_before_reset", 64'(rsp_valid[2]), 64'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    repeat (2) begin
      cycle();
      #2;
      check("q2_no_stale", 64'(rsp_valid[2]), 64'd0);
    end
    // Both reads must be accepted again with rsp_ready low: credits were cleared.
    do_req(2, 1'b0, rand_addr(), '0, 8'h00, 8'h23);
    do_req(2, 1'b0, rand_addr(), '0, 8'h00, 8'h24);
    rsp_ready[2] = 1'b1;
    repeat (3) cycle();

    // Write acknowledgement behaviour
    rsp_ready[3] = 1'b0;
    do_req(3, 1'b1, 32'h5, 64'hDEADBEEFCAFEF00D, 8'hFF, 8'h77);
    #2;
`ifdef VX_TI_MEM_WRITE_ACK_EN
    check("wack_valid", 64'(rsp_valid[3]), 64'd1);
    check("wack_data", rsp_data[3], 64'd0);
    check("wack_tag", 64'(rsp_tag[3]), 64'h77);
`else
    check("wack_none", 64'(rsp_valid[3]), 64'd0);
`endif
    rsp_ready[3] = 1'b1;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
